// File: rtl/bp_stall_profiler_counters.sv
// Stall-reason profiler: samples the per-cycle stall vector and retire strobe,
// priority-encodes each non-retiring cycle and keeps saturating per-reason counts.
module bp_stall_profiler_counters #(
  parameter int ctr_width_p   = 32,
  parameter int num_reasons_p = 33
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     commit_v_i,
  input  logic [num_reasons_p-1:0] stall_reason_i,
  input  logic                     rd_v_i,
  input  logic [5:0]               rd_addr_i,
  output logic                     rd_v_o,
  output logic [ctr_width_p-1:0]   rd_data_o,
  output logic [5:0]               last_reason_o
);

  localparam logic [5:0] CommitAddr = 6'(num_reasons_p);
  localparam logic [5:0] CycleAddr  = 6'(num_reasons_p + 1);

  // Stage-1 sample registers; deliberately untouched by clear_i.
  logic                     s1_en_q;
  logic                     s1_commit_q;
  logic [num_reasons_p-1:0] s1_reason_q;

  logic [ctr_width_p-1:0] ctr_q [num_reasons_p];
  logic [ctr_width_p-1:0] ctr_d [num_reasons_p];
  logic [ctr_width_p-1:0] commit_ctr_q, commit_ctr_d;
  logic [ctr_width_p-1:0] cycle_ctr_q, cycle_ctr_d;
  logic [5:0]             last_reason_q, last_reason_d;
  logic [5:0]             enc_code;
  logic                   rd_v_q;
  logic [ctr_width_p-1:0] rd_data_q, rd_data_d;

  function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Highest set bit wins; an empty vector encodes as unknown (0).
  always_comb begin
    enc_code = '0;
    for (int k = 0; k < num_reasons_p; k++) begin
      if (s1_reason_q[k]) enc_code = 6'(k);
    end
  end

  always_comb begin
    ctr_d         = ctr_q;
    commit_ctr_d  = commit_ctr_q;
    cycle_ctr_d   = cycle_ctr_q;
    last_reason_d = last_reason_q;
    if (clear_i) begin
      for (int k = 0; k < num_reasons_p; k++) ctr_d[k] = '0;
      commit_ctr_d = '0;
      cycle_ctr_d  = '0;
    end else if (s1_en_q) begin
      cycle_ctr_d = sat_inc(cycle_ctr_q);
      if (s1_commit_q) begin
        commit_ctr_d = sat_inc(commit_ctr_q);
      end else begin
        ctr_d[enc_code] = sat_inc(ctr_q[enc_code]);
        last_reason_d   = enc_code;
      end
    end
  end

  // Reads see the counter values from before the sampling edge.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_v_i) begin
      if (rd_addr_i < CommitAddr) begin
        rd_data_d = ctr_q[rd_addr_i];
      end else if (rd_addr_i == CommitAddr) begin
        rd_data_d = commit_ctr_q;
      end else if (rd_addr_i == CycleAddr) begin
        rd_data_d = cycle_ctr_q;
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_en_q       <= 1'b0;
      s1_commit_q   <= 1'b0;
      s1_reason_q   <= '0;
      for (int k = 0; k < num_reasons_p; k++) ctr_q[k] <= '0;
      commit_ctr_q  <= '0;
      cycle_ctr_q   <= '0;
      last_reason_q <= '0;
      rd_v_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      s1_en_q       <= en_i;
      s1_commit_q   <= commit_v_i;
      s1_reason_q   <= stall_reason_i;
      for (int k = 0; k < num_reasons_p; k++) ctr_q[k] <= ctr_d[k];
      commit_ctr_q  <= commit_ctr_d;
      cycle_ctr_q   <= cycle_ctr_d;
      last_reason_q <= last_reason_d;
      rd_v_q        <= rd_v_i;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_v_o        = rd_v_q;
  assign rd_data_o     = rd_data_q;
  assign last_reason_o = last_reason_q;

endmodule

// File: tb/tb_bp_stall_profiler_counters.sv
// Bench for bp_stall_profiler_counters: a 32-bit instance plus a 4-bit instance
// sharing stimulus; read responses are matched against an expected queue.
module tb_bp_stall_profiler_counters;

  logic        aclk;
  logic        aresetn;
  logic        en_i;
  logic        clear_i;
  logic        commit_v_i;
  logic [32:0] stall_reason_i;
  logic        rd_v_i;
  logic [5:0]  rd_addr_i;
  logic        rd_v_o, rd_v_w4;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_data_w4;
  logic [5:0]  last_reason_o, last_reason_w4;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  exp4_q[$];  // bit 4 set: also check the 4-bit instance

  bp_stall_profiler_counters #(.ctr_width_p(32), .num_reasons_p(33)) dut (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .clear_i(clear_i),
    .commit_v_i(commit_v_i), .stall_reason_i(stall_reason_i),
    .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_v_o(rd_v_o),
    .rd_data_o(rd_data_o), .last_reason_o(last_reason_o)
  );

  bp_stall_profiler_counters #(.ctr_width_p(4), .num_reasons_p(33)) dut_w4 (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .clear_i(clear_i),
    .commit_v_i(commit_v_i), .stall_reason_i(stall_reason_i),
    .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_v_o(rd_v_w4),
    .rd_data_o(rd_data_w4), .last_reason_o(last_reason_w4)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: pop one expected entry per read response.
  always @(negedge aclk) begin
    if (aresetn && rd_v_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_v", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        logic [4:0]  e4;
        e  = exp_q.pop_front();
        e4 = exp4_q.pop_front();
        check("rd_data", rd_data_o, e);
        if (e4[4]) begin
          check("rd_v_w4", 32'(rd_v_w4), 32'd1);
          check("rd_data_w4", 32'(rd_data_w4), 32'(e4[3:0]));
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input logic en, input logic commit, input logic clr,
                      input logic [32:0] reason, input logic rdv, input logic [5:0] addr);
    en_i = en; commit_v_i = commit; clear_i = clr; stall_reason_i = reason;
    rd_v_i = rdv; rd_addr_i = addr;
    @(posedge aclk); #1;
  endtask

  task automatic run(input int n, input logic en, input logic commit, input logic [32:0] reason);
    for (int i = 0; i < n; i++) step(en, commit, 1'b0, reason, 1'b0, 6'd0);
  endtask

  task automatic idle(input int n);
    run(n, 1'b0, 1'b0, 33'd0);
  endtask

  task automatic clear_all();
    step(1'b0, 1'b0, 1'b1, 33'd0, 1'b0, 6'd0);
    idle(2);
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp,
                         input logic chk4, input logic [3:0] exp4);
    exp_q.push_back(exp);
    exp4_q.push_back({chk4, exp4});
    step(1'b0, 1'b0, 1'b0, 33'd0, 1'b1, addr);
  endtask

  task automatic drain_reads();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge aclk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [32:0] r;
    aresetn = 1'b0;
    en_i = 0; clear_i = 0; commit_v_i = 0; stall_reason_i = '0; rd_v_i = 0; rd_addr_i = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Reset state
    check("reset_rd_v", 32'(rd_v_o), 32'd0);
    check("reset_rd_data", rd_data_o, 32'd0);
    check("reset_last_reason", 32'(last_reason_o), 32'd0);
    do_read(6'd34, 32'd0, 1'b0, 4'd0);

    // Unknown stalls
    run(10, 1'b1, 1'b0, 33'd0);
    idle(2);
    do_read(6'd0, 32'd10, 1'b0, 4'd0);
    do_read(6'd34, 32'd10, 1'b0, 4'd0);
    do_read(6'd33, 32'd0, 1'b0, 4'd0);
    idle(1);
    check("t1_last_reason", 32'(last_reason_o), 32'd0);

    // Priority: ic_miss beats dc_miss
    clear_all();
    r = '0; r[32] = 1'b1; r[3] = 1'b1;
    run(1, 1'b1, 1'b0, r);
    r = '0; r[3] = 1'b1;
    run(1, 1'b1, 1'b0, r);
    idle(2);
    do_read(6'd32, 32'd1, 1'b0, 4'd0);
    do_read(6'd3, 32'd1, 1'b0, 4'd0);
    do_read(6'd0, 32'd0, 1'b0, 4'd0);
    do_read(6'd34, 32'd2, 1'b0, 4'd0);
    idle(1);
    check("t2_last_reason", 32'(last_reason_o), 32'd3);

    // Commit suppresses stall counting
    clear_all();
    r = '0; r[20] = 1'b1;
    run(5, 1'b1, 1'b1, r);
    idle(2);
    do_read(6'd33, 32'd5, 1'b0, 4'd0);
    do_read(6'd20, 32'd0, 1'b0, 4'd0);
    do_read(6'd34, 32'd5, 1'b0, 4'd0);
    idle(1);
    check("t3_last_reason", 32'(last_reason_o), 32'd3);

    // Saturation on the 4-bit instance
    clear_all();
    r = '0; r[13] = 1'b1;
    run(20, 1'b1, 1'b0, r);
    idle(2);
    do_read(6'd13, 32'd20, 1'b1, 4'd15);
    do_read(6'd34, 32'd20, 1'b1, 4'd15);
    do_read(6'd33, 32'd0, 1'b1, 4'd0);
    idle(1);
    check("t4_last_reason", 32'(last_reason_o), 32'd13);

    // Disabled cycles freeze everything
    r = '0; r[5] = 1'b1;
    run(8, 1'b0, 1'b0, r);
    idle(2);
    do_read(6'd13, 32'd20, 1'b0, 4'd0);
    do_read(6'd5, 32'd0, 1'b0, 4'd0);
    do_read(6'd34, 32'd20, 1'b0, 4'd0);

    // Clear at the edge that would count an enabled sample
    r = '0; r[7] = 1'b1;
    run(1, 1'b1, 1'b0, r);
    step(1'b0, 1'b0, 1'b1, 33'd0, 1'b0, 6'd0);
    do_read(6'd34, 32'd0, 1'b0, 4'd0);
    do_read(6'd7, 32'd0, 1'b0, 4'd0);
    do_read(6'd13, 32'd0, 1'b0, 4'd0);
    idle(1);
    check("t5_last_reason", 32'(last_reason_o), 32'd13);

    // Reads while incrementing: read at enabled cycle j returns j-1
    for (int j = 0; j < 7; j++) begin
      if (j == 4 || j == 5) begin
        exp_q.push_back(32'(j - 1));
        exp4_q.push_back(5'd0);
        step(1'b1, 1'b0, 1'b0, 33'd0, 1'b1, 6'd34);
      end else if (j == 6) begin
        exp_q.push_back(32'd0);
        exp4_q.push_back(5'd0);
        step(1'b1, 1'b0, 1'b0, 33'd0, 1'b1, 6'd40);
      end else begin
        step(1'b1, 1'b0, 1'b0, 33'd0, 1'b0, 6'd0);
      end
    end
    idle(1);
    drain_reads();

    // Reset in the middle of a read
    en_i = 1'b1; rd_v_i = 1'b1; rd_addr_i = 6'd34;
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check("mid_reset_rd_v", 32'(rd_v_o), 32'd0);
    check("mid_reset_rd_data", rd_data_o, 32'd0);
    check("mid_reset_last_reason", 32'(last_reason_o), 32'd0);
    en_i = 1'b0; rd_v_i = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(6'd34, 32'd0, 1'b0, 4'd0);
    do_read(6'd0, 32'd0, 1'b0, 4'd0);
    idle(1);
    check("post_reset_rd_v", 32'(rd_v_o), 32'd0);
    drain_reads();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
